// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and the frame parity check.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_CNT_W      = 4;

    // Scan-code prefixes seen by the keyboard consumer.
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND = 8'hE0;

    // Odd parity: the eight data bits together with the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO for received scan codes; pointers carry one extra wrap bit.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is only accepted when a pop frees the head in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head reads 8'h00 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pin synchroniser, frame deserialiser/checker, scan-code FIFO.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ps2read_nextdata,
    output logic [7:0] ps2read_data,
    output logic       ps2read_ready,
    output logic       ps2read_overflow,
    output logic       ps2read_frame_err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PS2_CNT_W-1:0] LAST_BIT = PS2_CNT_W'(PS2_FRAME_BITS - 1);
    localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]           clk_sync_q;
    logic [2:0]           data_sync_q;
    logic [PS2_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [9:0]           shift_q, shift_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_err_q, frame_err_d;

    logic       fall;
    logic       data_bit;
    logic       last_bit;
    logic       frame_ok;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] fifo_rdata;

    // Stage 1 is the newer and stage 2 the older synchronised sample of the PS/2 clock.
    assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = data_sync_q[1];
    assign last_bit = (bit_cnt_q == LAST_BIT);

    // shift_q holds start (bit 0), data (bits 8:1) and parity (bit 9); the stop bit is live.
    assign frame_ok = ~shift_q[0] & data_bit & odd_parity_ok(shift_q[8:1], shift_q[9]);
    assign push     = fall & last_bit & frame_ok;
    assign pop      = ~fifo_empty & ~ps2read_nextdata;

    assign ps2read_ready     = ~fifo_empty;
    assign ps2read_data      = fifo_rdata;
    assign ps2read_overflow  = overflow_q;
    assign ps2read_frame_err = frame_err_q;

    // Three-flop synchronisers; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    end

    // Frame deserialiser, idle timeout and result flags next-state.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        idle_d      = idle_q;
        overflow_d  = overflow_q | (push & fifo_full & ~pop);
        frame_err_d = fall & last_bit & ~frame_ok;
        if (fall) begin
            idle_d = '0;
            if (last_bit) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = {data_bit, shift_q[9:1]};
            end
        end else if (bit_cnt_q != '0) begin
            // A stalled partial frame is dropped without flagging an error.
            if (idle_q == IDLE_MAX) begin
                bit_cnt_d = '0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    // Frame and flag state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            idle_q      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i (shift_q[8:1]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx with a queue-based reference model.
module tb_ps2_keyboard_rx;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 600;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata = 1'b1;
    logic [7:0] rd_data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int n_checks   = 0;
    int n_fail     = 0;
    int err_cycles = 0;

    byte unsigned model_q[$];
    bit           model_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ps2_clk           (ps2_clk),
        .ps2_data          (ps2_data),
        .ps2read_nextdata  (nextdata),
        .ps2read_data      (rd_data),
        .ps2read_ready     (ready),
        .ps2read_overflow  (overflow),
        .ps2read_frame_err (frame_err)
    );

    // Total number of cycles the frame-error flag was seen high.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cycles++;
    end

    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    // Sends a full frame and returns right after driving the stop-bit clock fall.
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int half);
        logic [10:0] f;
        f = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        send_bits(f, 10, half);
        @(negedge clk);
        ps2_data = f[10];
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic end_frame(input int half);
        repeat (half) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Frame plus the reference model's view of what it does to the buffer.
    task automatic frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                         input int half);
        send_frame(data, bad_par, bad_stop, half);
        end_frame(half);
        if (!bad_par && !bad_stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(data);
            else model_ovf = 1'b1;
        end
    endtask

    // Consumer with nextdata = ~ready: one byte per cycle, then empty.
    task automatic drain(input string name);
        while (model_q.size() != 0) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || rd_data !== model_q[0]) begin
                n_fail++;
                $display("FAIL %s drain: ready=%b data=%h, expected ready=1 data=%h",
                         name, ready, rd_data, model_q[0]);
            end
            nextdata = 1'b0;
            void'(model_q.pop_front());
        end
        @(negedge clk);
        nextdata = 1'b1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s empty-after-drain: ready=%b, expected 0", name, ready);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (ready !== 1'b0 || rd_data !== 8'h00 || overflow !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: ready=%b data=%h ovf=%b ferr=%b, expected 0 00 0 0",
                     name, ready, rd_data, overflow, frame_err);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        check_idle_outputs("reset_values");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_single();
        int e0;
        e0 = err_cycles;
        send_frame(8'h1C, 1'b0, 1'b0, 100);
        repeat (2) @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_early: ready=%b, expected 0", ready);
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || rd_data !== 8'h1C) begin
            n_fail++;
            $display("FAIL single_ready: ready=%b data=%h, expected 1 1c", ready, rd_data);
        end
        end_frame(100);
        n_checks++;
        if (err_cycles != e0) begin
            n_fail++;
            $display("FAIL single_no_err: err cycles %0d, expected 0", err_cycles - e0);
        end
        @(negedge clk);
        nextdata = 1'b0;
        @(negedge clk);
        nextdata = 1'b1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: ready=%b, expected 0", ready);
        end
    endtask

    task automatic test_two_frames();
        frame(8'hF0, 1'b0, 1'b0, 20);
        frame(8'h1C, 1'b0, 1'b0, 20);
        drain("two_frames");
    endtask

    task automatic test_frame_errors();
        for (int k = 0; k < 2; k++) begin
            int e0;
            e0 = err_cycles;
            send_frame(8'h1C, (k == 0), (k == 1), 20);
            repeat (3) @(negedge clk);
            n_checks++;
            if (frame_err !== 1'b1 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_err_pulse[%0d]: ferr=%b ready=%b, expected 1 0",
                         k, frame_err, ready);
            end
            @(negedge clk);
            n_checks++;
            if (frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_err_width[%0d]: ferr=%b, expected 0", k, frame_err);
            end
            end_frame(20);
            n_checks++;
            if (err_cycles - e0 != 1 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_err_total[%0d]: err cycles %0d ready=%b, expected 1 0",
                         k, err_cycles - e0, ready);
            end
        end
    endtask

    task automatic test_timeout();
        int          e0;
        logic [10:0] partial;
        partial = {1'b1, 1'b1, 8'hA5, 1'b0};
        send_bits(partial, 5, 20);
        repeat (TIMEOUT + 100) @(negedge clk);
        e0 = err_cycles;
        frame(8'h1C, 1'b0, 1'b0, 20);
        n_checks++;
        if (err_cycles != e0) begin
            n_fail++;
            $display("FAIL timeout_no_err: err cycles %0d, expected 0", err_cycles - e0);
        end
        drain("timeout");
    endtask

    task automatic test_random();
        for (int n = 0; n < 7; n++) begin
            logic [7:0] d;
            int         r;
            int         half;
            int         e0;
            d    = 8'($urandom);
            r    = $urandom_range(0, 7);
            half = $urandom_range(8, 30);
            e0   = err_cycles;
            frame(d, (r == 0), (r == 1), half);
            n_checks++;
            if (err_cycles - e0 != ((r <= 1) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL random_err[%0d]: err cycles %0d for byte %h kind %0d",
                         n, err_cycles - e0, d, r);
            end
            if ($urandom_range(0, 1) == 1) drain("random_mid");
        end
        drain("random_end");
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 8; i++) frame(8'(8'h20 + i), 1'b0, 1'b0, 20);
        send_frame(8'h55, 1'b0, 1'b0, 20);
        repeat (2) @(negedge clk);
        nextdata = 1'b0;
        @(negedge clk);
        nextdata = 1'b1;
        void'(model_q.pop_front());
        model_q.push_back(8'h55);
        end_frame(20);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop_ovf: ovf=%b, expected 0", overflow);
        end
        drain("full_push_pop");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b0, 20);
        n_checks++;
        if (overflow !== model_ovf) begin
            n_fail++;
            $display("FAIL overflow_flag: ovf=%b, expected %b", overflow, model_ovf);
        end
        drain("overflow");
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: ovf=%b, expected 1", overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] partial;
        partial = {1'b1, 1'b0, 8'h3C, 1'b0};
        frame(8'h11, 1'b0, 1'b0, 20);
        frame(8'h22, 1'b0, 1'b0, 20);
        send_bits(partial, 5, 20);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_mid_frame");
        rst = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        frame(8'h1C, 1'b0, 1'b0, 20);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf_cleared: ovf=%b, expected 0", overflow);
        end
        drain("after_reset");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_two_frames();
        test_frame_errors();
        test_timeout();
        test_random();
        test_full_push_pop();
        test_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
